ps2_command_out: RTL

- Host-to-device transmitter for the PS/2 port; the counterpart to the PS/2 data receiver inside the PS/2 core.
- Accepts an 8-bit command from the controller logic and performs the full host-initiated transfer:
  - clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop bit, then checks the device acknowledge.
- Drives the PS/2 lines only through open-drain "drive low" enables. The core top level owns the tristates and the clock edge detection.

---
 rtl/ps2_command_out_pkg.sv | 37 +++
 rtl/ps2_command_out_timeout_counter.sv | 24 ++
 rtl/ps2_command_out.sv | 107 ++++++++++
 3 files changed

// File: rtl/ps2_command_out_pkg.sv
// ps2_command_out_pkg: shared PS/2 state encoding, 50 MHz timing defaults and parity helper.
package ps2_command_out_pkg;

    localparam int PS2_INHIBIT_CYCLES      = 5050;
    localparam int PS2_RTS_TIMEOUT_CYCLES  = 750000;
    localparam int PS2_XFER_TIMEOUT_CYCLES = 100000;
    localparam int PS2_CNT_W               = 20;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_INHIBIT  = 4'd1;
    localparam logic [3:0] ST_RTS      = 4'd2;
    localparam logic [3:0] ST_DATA     = 4'd3;
    localparam logic [3:0] ST_PARITY   = 4'd4;
    localparam logic [3:0] ST_STOP     = 4'd5;
    localparam logic [3:0] ST_ACK_WAIT = 4'd6;
    localparam logic [3:0] ST_ACK_REL  = 4'd7;
    localparam logic [3:0] ST_COMPLETE = 4'd8;
    localparam logic [3:0] ST_ERROR    = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_INHIBIT  = ST_INHIBIT,
        S_RTS      = ST_RTS,
        S_DATA     = ST_DATA,
        S_PARITY   = ST_PARITY,
        S_STOP     = ST_STOP,
        S_ACK_WAIT = ST_ACK_WAIT,
        S_ACK_REL  = ST_ACK_REL,
        S_COMPLETE = ST_COMPLETE,
        S_ERROR    = ST_ERROR
    } tx_state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_command_out_timeout_counter.sv
// ps2_timeout_counter: clearable cycle counter that flags the final cycle of a TERMINAL-long window.
module ps2_timeout_counter #(
    parameter int CNT_W    = 20,
    parameter int TERMINAL = 5050
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [CNT_W-1:0] count;

    assign done = enable && (count == CNT_W'(TERMINAL - 1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ps2_command_out.sv
// ps2_command_out: PS/2 host-to-device command transmitter driving open-drain low enables.
// Performs inhibit, request-to-send, 8 data bits LSB first, odd parity, stop and ack check.
module ps2_command_out
    import ps2_command_out_pkg::*;
#(
    parameter int INHIBIT_CYCLES      = PS2_INHIBIT_CYCLES,
    parameter int RTS_TIMEOUT_CYCLES  = PS2_RTS_TIMEOUT_CYCLES,
    parameter int XFER_TIMEOUT_CYCLES = PS2_XFER_TIMEOUT_CYCLES,
    parameter int CNT_W               = PS2_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    tx_state_t  state, state_next;
    logic [7:0] cmd_reg;
    logic       parity;
    logic [2:0] bit_count;
    logic       inhibit_done, rts_done, xfer_done;
    logic       in_xfer;

    // The transfer window spans first device falling edge through ack release.
    assign in_xfer = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP) ||
                     (state == S_ACK_WAIT) || (state == S_ACK_REL);

    ps2_timeout_counter #(.CNT_W(CNT_W), .TERMINAL(INHIBIT_CYCLES)) u_inhibit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != S_INHIBIT),
        .enable (state == S_INHIBIT),
        .done   (inhibit_done)
    );

    ps2_timeout_counter #(.CNT_W(CNT_W), .TERMINAL(RTS_TIMEOUT_CYCLES)) u_rts_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != S_RTS),
        .enable (state == S_RTS),
        .done   (rts_done)
    );

    ps2_timeout_counter #(.CNT_W(CNT_W), .TERMINAL(XFER_TIMEOUT_CYCLES)) u_xfer_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_xfer),
        .enable (in_xfer),
        .done   (xfer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_reg   <= '0;
            parity    <= 1'b0;
            bit_count <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && send_command) begin
                cmd_reg <= the_command;
                parity  <= odd_parity(the_command);
            end
            if (state == S_RTS)
                bit_count <= '0;
            else if (state == S_DATA && ps2_clk_negedge && !xfer_done && bit_count != 3'd7)
                bit_count <= bit_count + 1'b1;
        end
    end

    // Timeouts are tested before edges so a coincident timeout wins.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = send_command ? S_INHIBIT : S_IDLE;
            S_INHIBIT:  state_next = inhibit_done ? S_RTS : S_INHIBIT;
            S_RTS:      state_next = rts_done ? S_ERROR : ps2_clk_negedge ? S_DATA : S_RTS;
            S_DATA:     state_next = xfer_done ? S_ERROR :
                                     (ps2_clk_negedge && bit_count == 3'd7) ? S_PARITY : S_DATA;
            S_PARITY:   state_next = xfer_done ? S_ERROR : ps2_clk_negedge ? S_STOP : S_PARITY;
            S_STOP:     state_next = xfer_done ? S_ERROR : ps2_clk_negedge ? S_ACK_WAIT : S_STOP;
            S_ACK_WAIT: state_next = xfer_done ? S_ERROR :
                                     (ps2_clk_posedge && !ps2_data) ? S_ACK_REL : S_ACK_WAIT;
            S_ACK_REL:  state_next = xfer_done ? S_ERROR : ps2_data ? S_COMPLETE : S_ACK_REL;
            S_COMPLETE: state_next = send_command ? S_COMPLETE : S_IDLE;
            S_ERROR:    state_next = send_command ? S_ERROR : S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    assign ps2_clk_drive_low  = (state == S_INHIBIT);
    assign ps2_data_drive_low = (state == S_RTS) ? 1'b1 :
                                (state == S_DATA) ? ~cmd_reg[bit_count] :
                                (state == S_PARITY) ? ~parity : 1'b0;
    assign busy                          = (state != S_IDLE);
    assign command_was_sent              = (state == S_COMPLETE);
    assign error_communication_timed_out = (state == S_ERROR);

endmodule
